// File: rtl/keypad_debouncer.sv
// -----------------------------------------------------------------------------
// keypad_debouncer
//
// Debounces the four column lines of a scanned keypad. The raw pins are first
// brought into the clk domain through a two-flop synchronizer that runs on
// every clk. The debounce FSM, the candidate pattern and the stability counter
// only advance on clk edges where the scan-rate strobe `tick` is high. A new
// pattern must be seen on DEBOUNCE_TICKS consecutive ticks before it is
// accepted. The same rule applies before a release is accepted.
//
// Ports
//   clk        in   system clock (40 MHz)
//   nreset     in   asynchronous active-low reset
//   tick       in   one-clk-wide sample strobe from the scan-rate counter
//   col_raw    in   [3:0] raw column pins, active-high, asynchronous to clk
//   col_clean  out  [3:0] debounced column pattern for the scanner FSM
//   pressed    out  one-clk pulse when a press is accepted
//   released   out  one-clk pulse when a release is accepted
//   busy       out  high while a press or a release is being qualified
//
// Parameters
//   DEBOUNCE_TICKS  consecutive equal tick samples needed to accept a change
//                   (2..255)
// -----------------------------------------------------------------------------
module keypad_debouncer #(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       tick,
    input  logic [3:0] col_raw,
    output logic [3:0] col_clean,
    output logic       pressed,
    output logic       released,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    // The count already holds the number of matching samples seen so far.
    // When it equals DEBOUNCE_TICKS-1, the current tick is the accepting one.
    // Comparing against this constant means cnt never has to hold
    // DEBOUNCE_TICKS itself, so it cannot overflow at the top of the range.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_TICKS - 1);

    if (DEBOUNCE_TICKS < 2 || DEBOUNCE_TICKS > 255) begin : g_bad_param
        $error("keypad_debouncer: DEBOUNCE_TICKS must be in 2..255");
    end

    // -------------------------------------------------------------------------
    // Synchronizer: samples on every clk, independent of tick
    // -------------------------------------------------------------------------
    logic [3:0] sync_meta_d, sync_meta_q;
    logic [3:0] sync_d,      sync_q;

    always_comb begin
        sync_meta_d = col_raw;
        sync_d      = sync_meta_q;
    end

    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge values; blocking here would let sync_q see this cycle's
    // sync_meta_q and collapse the two stages into one.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_meta_q <= 4'b0000;
            sync_q      <= 4'b0000;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSM
    // -------------------------------------------------------------------------
    state_e     state_d,     state_q;
    logic [3:0] cand_d,      cand_q;
    logic [7:0] cnt_d,       cnt_q;
    logic [3:0] col_clean_d, col_clean_q;
    logic       pressed_d,   pressed_q;
    logic       released_d,  released_q;

    // NOTE: every signal this block drives gets a default before the case.
    // If any branch left one unassigned, synthesis would infer a latch.
    // The pulse defaults are 0, so pulses drop on the next clk even when no
    // tick arrives.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        col_clean_d = col_clean_q;
        pressed_d   = 1'b0;
        released_d  = 1'b0;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (sync_q != 4'b0000) begin
                        cand_d  = sync_q;
                        cnt_d   = 8'd1;
                        state_d = PRESS_WAIT;
                    end
                end

                PRESS_WAIT: begin
                    if (sync_q == cand_q) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d     = HELD;
                            col_clean_d = cand_q;
                            pressed_d   = 1'b1;
                            cnt_d       = 8'd0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else if (sync_q == 4'b0000) begin
                        // Bounce back to all-open: abandon silently.
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        // A different key combination: restart on it.
                        cand_d = sync_q;
                        cnt_d  = 8'd1;
                    end
                end

                HELD: begin
                    if (sync_q != cand_q) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = 8'd1;
                    end
                end

                RELEASE_WAIT: begin
                    if (sync_q == cand_q) begin
                        // The key came back: this was release bounce.
                        state_d = HELD;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d     = IDLE;
                        col_clean_d = 4'b0000;
                        released_d  = 1'b1;
                        cnt_d       = 8'd0;
                    end else begin
                        // Any departure from cand counts toward release,
                        // including a different nonzero pattern.
                        cnt_d = cnt_q + 8'd1;
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // NOTE: only control and datapath flops exist here, and all of them are
    // reset. Reset must drop the outputs immediately and must never produce a
    // pulse, which holds because the pulse flops are cleared like everything
    // else.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            cand_q      <= 4'b0000;
            cnt_q       <= 8'd0;
            col_clean_q <= 4'b0000;
            pressed_q   <= 1'b0;
            released_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            col_clean_q <= col_clean_d;
            pressed_q   <= pressed_d;
            released_q  <= released_d;
        end
    end

    assign col_clean = col_clean_q;
    assign pressed   = pressed_q;
    assign released  = released_q;
    assign busy      = (state_q == PRESS_WAIT) || (state_q == RELEASE_WAIT);

`ifndef SYNTHESIS
    a_cnt_bound : assert property (@(posedge clk) disable iff (!nreset)
        cnt_q <= CNT_LAST);
    a_pulse_excl : assert property (@(posedge clk) disable iff (!nreset)
        !(pressed_q && released_q));
`endif

endmodule

// File: tb/tb_keypad_debouncer.sv
// -----------------------------------------------------------------------------
// tb_keypad_debouncer
//
// Uses DEBOUNCE_TICKS=4, with a tick every 8 clk. Stimulus changes col_raw
// right after a tick edge. The synchronizer has therefore settled before the
// next tick, and each call to apply() feeds a fixed number of tick samples.
//
// Each expected pulse (kind, col_clean, tick index) is queued before its
// stimulus is issued. A monitor checks each pulse against the queue on the
// falling clock edge. It also checks pulse width, exclusivity, press/release
// alternation and the col_clean invariant on every cycle.
// -----------------------------------------------------------------------------
module tb_keypad_debouncer;

    localparam int TICKS = 4;

    logic       clk = 1'b0;
    logic       nreset;
    logic       tick = 1'b0;
    logic [3:0] col_raw;
    logic [3:0] col_clean;
    logic       pressed;
    logic       released;
    logic       busy;

    keypad_debouncer #(.DEBOUNCE_TICKS(TICKS)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .tick      (tick),
        .col_raw   (col_raw),
        .col_clean (col_clean),
        .pressed   (pressed),
        .released  (released),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One-clk tick every 8 clk, changed on the falling edge.
    initial begin
        forever begin
            repeat (7) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    int tick_num = 0;
    always @(posedge clk) if (tick) tick_num <= tick_num + 1;

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_chk++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t, tick %0d)",
                     name, actual, expected, $time, tick_num);
        end
    endtask

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;

    typedef struct {
        int kind;
        int col;
        int at_tick;
    } evt_t;

    evt_t sb_q[$];
    bit   sb_en = 1'b1;

    task automatic expect_evt(input int kind, input int col, input int ticks_ahead);
        evt_t e;
        e.kind    = kind;
        e.col     = col;
        e.at_tick = tick_num + ticks_ahead;
        sb_q.push_back(e);
    endtask

    task automatic sb_match(input int kind);
        evt_t e;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got kind %0d pulse at tick %0d, expected no pulse",
                     kind, tick_num);
        end else begin
            e = sb_q.pop_front();
            check("evt_kind", kind, e.kind);
            check("evt_tick", tick_num, e.at_tick);
            check("evt_col", int'(col_clean), e.col);
        end
    endtask

    // Monitor: protocol invariants every cycle, scoreboard on each pulse.
    bit held     = 1'b0;
    int held_col = 0;
    bit prev_p   = 1'b0;
    bit prev_r   = 1'b0;

    always @(negedge clk) begin
        if (!nreset) begin
            held   = 1'b0;
            prev_p = 1'b0;
            prev_r = 1'b0;
        end else begin
            check("pulse_exclusive", int'(pressed & released), 0);
            if (pressed) begin
                check("pressed_width", int'(prev_p), 0);
                check("press_after_release", int'(held), 0);
                held     = 1'b1;
                held_col = int'(col_clean);
                check("press_col_nonzero", int'(col_clean != 4'b0000), 1);
                if (sb_en) sb_match(EV_PRESS);
            end
            if (released) begin
                check("released_width", int'(prev_r), 0);
                check("release_after_press", int'(held), 1);
                held = 1'b0;
                if (sb_en) sb_match(EV_RELEASE);
            end
            if (held) check("col_clean_hold", int'(col_clean), held_col);
            else      check("col_clean_idle", int'(col_clean), 0);
            prev_p = pressed;
            prev_r = released;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic apply(input logic [3:0] pat, input int n);
        col_raw = pat;
        ticks(n);
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    endtask

    initial begin
        #1_000_000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        summary();
        $finish;
    end

    // -------------------------------------------------------------------------
    // Directed sequences
    // -------------------------------------------------------------------------
    initial begin
        nreset  = 1'b0;
        col_raw = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        check("rst_col_clean", int'(col_clean), 0);
        check("rst_pressed", int'(pressed), 0);
        check("rst_released", int'(released), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        nreset = 1'b1;
        ticks(1);
        apply(4'b0000, 2);
        check("idle_busy", int'(busy), 0);

        // Clean press of 0100, released after 10 ticks.
        expect_evt(EV_PRESS, 4'b0100, 4);
        apply(4'b0100, 2);
        check("press_wait_busy", int'(busy), 1);
        check("press_wait_col", int'(col_clean), 0);
        apply(4'b0100, 8);
        check("held_col", int'(col_clean), 4'b0100);
        check("held_busy", int'(busy), 0);
        expect_evt(EV_RELEASE, 0, 4);
        apply(4'b0000, 2);
        check("release_wait_busy", int'(busy), 1);
        check("release_wait_col", int'(col_clean), 4'b0100);
        apply(4'b0000, 4);
        check("after_release_col", int'(col_clean), 0);

        // Press bounce: 0001/0000 alternating for 6 ticks, then 0001 held.
        expect_evt(EV_PRESS, 4'b0001, 10);
        for (int i = 0; i < 6; i++) apply((i % 2 == 0) ? 4'b0001 : 4'b0000, 1);
        apply(4'b0001, 8);
        expect_evt(EV_RELEASE, 0, 4);
        apply(4'b0000, 6);

        // Release bounce from HELD at 0010.
        expect_evt(EV_PRESS, 4'b0010, 4);
        apply(4'b0010, 6);
        expect_evt(EV_RELEASE, 0, 7);
        apply(4'b0000, 2);
        apply(4'b0010, 1);
        check("bounce_back_held_col", int'(col_clean), 4'b0010);
        check("bounce_back_busy", int'(busy), 0);
        apply(4'b0000, 6);

        // Pattern change: 0001 for 2 ticks, then 1000 held.
        expect_evt(EV_PRESS, 4'b1000, 6);
        apply(4'b0001, 2);
        apply(4'b1000, 6);
        expect_evt(EV_RELEASE, 0, 4);
        apply(4'b0000, 6);

        // Release into a different nonzero pattern: accepted as a release,
        // after which the new pattern is qualified as a fresh press.
        expect_evt(EV_PRESS, 4'b0100, 4);
        apply(4'b0100, 6);
        expect_evt(EV_RELEASE, 0, 4);
        expect_evt(EV_PRESS, 4'b0011, 8);
        apply(4'b0011, 10);
        expect_evt(EV_RELEASE, 0, 4);
        apply(4'b0000, 6);

        // Reset during HELD with the key still down.
        expect_evt(EV_PRESS, 4'b0100, 4);
        apply(4'b0100, 6);
        #2 nreset = 1'b0;
        #1;
        check("midrst_col_clean", int'(col_clean), 0);
        check("midrst_pressed", int'(pressed), 0);
        check("midrst_released", int'(released), 0);
        check("midrst_busy", int'(busy), 0);
        ticks(1);
        nreset = 1'b1;
        expect_evt(EV_PRESS, 4'b0100, 4);
        apply(4'b0100, 6);
        check("rearm_col", int'(col_clean), 4'b0100);
        expect_evt(EV_RELEASE, 0, 4);
        apply(4'b0000, 6);
        check("sb_drained_directed", sb_q.size(), 0);

        // Random dwell times: only the protocol invariants are checked here.
        sb_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] pat;
            pat = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            apply(pat, $urandom_range(1, 6));
        end
        apply(4'b0000, 6);
        check("random_end_busy", int'(busy), 0);
        check("random_end_col", int'(col_clean), 0);
        check("random_end_held", int'(held), 0);

        check("sb_drained", sb_q.size(), 0);
        summary();
        $finish;
    end

endmodule

// File: doc/keypad_debouncer.md
KEYPAD_DEBOUNCER -- requirements
Module: keypad_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 4, the number of consecutive equal tick samples needed to accept a change; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, system clock (40 MHz).
REQ-003 SHALL have port nreset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tick, input, 1, one-clk-wide sample strobe from the scan-rate counter.
REQ-005 SHALL have port col_raw, input, 4, raw keypad column pins (active-high, asynchronous).
REQ-006 SHALL have port col_clean, output, 4, debounced column pattern fed to the scanner FSM.
REQ-007 SHALL have port pressed, output, 1, one-clk pulse when a press is accepted.
REQ-008 SHALL have port released, output, 1, one-clk pulse when a release is accepted.
REQ-009 SHALL have port busy, output, 1, high in PRESS_WAIT and RELEASE_WAIT.

Function
REQ-010 SHALL pass col_raw through a 2-flop synchronizer clocked every clk; its output is "sync".
REQ-011 SHALL register a 4-bit candidate "cand" and an 8-bit counter "cnt"; FSM state, cand and cnt SHALL update only on clk edges where tick=1; the synchronizer is not tick-gated.
REQ-012 SHALL implement states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-013 IDLE: col_clean=0; if sync!=0, then cand<=sync, cnt<=1, go to PRESS_WAIT; otherwise remain.
REQ-014 PRESS_WAIT, sync==cand: if cnt+1==DEBOUNCE_TICKS, go to HELD, col_clean<=cand, pulse pressed; otherwise cnt<=cnt+1.
REQ-015 PRESS_WAIT, sync==0: go to IDLE, cnt<=0, with no pulse.
REQ-016 PRESS_WAIT, sync nonzero and !=cand: cand<=sync, cnt<=1, remain in PRESS_WAIT (restart).
REQ-017 HELD: col_clean holds cand; if sync!=cand, go to RELEASE_WAIT with cnt<=1; otherwise remain.
REQ-018 RELEASE_WAIT, sync==cand: return to HELD, cnt<=0, with no pulse; this is release bounce.
REQ-019 RELEASE_WAIT, sync!=cand (any other pattern, including nonzero): if cnt+1==DEBOUNCE_TICKS, go to IDLE, col_clean<=0, pulse released; otherwise cnt<=cnt+1.
REQ-020 col_clean SHALL change only on pressed/released events and SHALL hold its value through PRESS_WAIT and RELEASE_WAIT.
REQ-021 pressed and released SHALL be registered, high for exactly the one clk following the accepting tick edge, and never high together.
REQ-022 Press latency SHALL be: col_raw stable at 2 clk plus DEBOUNCE_TICKS ticks plus 1 clk to pressed.
REQ-023 cnt SHALL never exceed DEBOUNCE_TICKS-1 and SHALL never wrap.
REQ-024 With tick held continuously high, the block SHALL behave identically, with every clk acting as a tick.
REQ-025 Clk edges where tick=0 SHALL leave state, cand, cnt, col_clean, pressed and released unchanged, except that pulses SHALL deassert.

Reset
REQ-026 nreset low SHALL asynchronously force: both synchronizer flops=0, state=IDLE, cand=0, cnt=0, col_clean=0, pressed=0, released=0, busy=0.
REQ-027 Reset asserted mid-debounce or during HELD SHALL abort without any pulse, and SHALL emit no released pulse for a key still held.
REQ-028 After nreset deasserts, a key held throughout SHALL be re-accepted via the normal PRESS_WAIT path.

Verification (DEBOUNCE_TICKS=4, tick every 8 clk)
REQ-029 Clean press: col_raw=0100 held, then released after 10 ticks -> col_clean=0100 and one pressed pulse at the 4th tick after sync; released pulse 4 ticks after release; col_clean=0000.
REQ-030 Press bounce: col_raw toggles 0001/0000 on alternate ticks for 6 ticks, then 0001 held -> no pulse during bounce; pressed exactly once, 4 ticks after the toggling stops.
REQ-031 Release bounce: from HELD at 0010, col_raw goes 0000 for 2 ticks, 0010 for 1 tick, then 0000 -> no released pulse until 4 consecutive 0000 ticks; exactly one released pulse.
REQ-032 Pattern change: col_raw=0001 for 2 ticks, then 1000 held -> cand restarts; col_clean=1000 after 4 ticks of 1000; never 0001.
REQ-033 Reset mid-operation: nreset pulsed low during HELD with col_raw=0100 -> all outputs 0 immediately, no released pulse; pressed again 2 clk + 4 ticks after release of reset.
REQ-034 Pulse width and exclusivity: over random col_raw with 1 to 6 tick dwell times, check that every pulse is 1 clk wide, pressed and released alternate starting with pressed, and col_clean is nonzero exactly between them.
